adder_rs_array: RTL and testbench

//  Parametrised adder/logic reservation-station array for the Tomasulo core: NUM_RS

---
 rtl/adder_rs_array.sv | 249 ++++++++++++++++++++++++
 tb/tb_adder_rs_array.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_rs_array.sv
// Adder/logic reservation-station array: NUM_RS stations feeding one
// multi-cycle ALU with a single CDB requester, oldest-ready-first dispatch.
module adder_rs_array #(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 6,
  parameter int NUM_RS  = 4,
  parameter int RS_BASE = 1,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue,
  input  logic [2:0]        opcode,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              A_invalid,
  input  logic              B_invalid,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_grant,
  output logic              cdb_rts,
  output logic              cdb_out_valid,
  output logic [TAG_W-1:0]  cdb_out_tag,
  output logic [DATA_W-1:0] cdb_out_data,
  output logic              available,
  output logic [TAG_W-1:0]  rs_available,
  output logic [TAG_W-1:0]  issued,
  output logic [TAG_W-1:0]  rs_executing,
  output logic              error
);

  localparam int IDX_W = $clog2(NUM_RS);
  localparam int AGE_W = $clog2(NUM_RS) + 1;
  localparam int CNT_W = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {ALU_IDLE, ALU_EXEC, ALU_WAIT} alu_state_e;

  // Station storage
  logic              busy_q [NUM_RS];
  logic [2:0]        op_q   [NUM_RS];
  logic [TAG_W-1:0]  qj_q   [NUM_RS];
  logic [TAG_W-1:0]  qk_q   [NUM_RS];
  logic [DATA_W-1:0] vj_q   [NUM_RS];
  logic [DATA_W-1:0] vk_q   [NUM_RS];
  logic [AGE_W-1:0]  age_q  [NUM_RS];

  // ALU / CDB side
  alu_state_e        state_q;
  logic [IDX_W-1:0]  exec_idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cdb_rts_q;
  logic [TAG_W-1:0]  out_tag_q;
  logic [DATA_W-1:0] out_data_q;
  logic [TAG_W-1:0]  rs_exec_q;
  logic [TAG_W-1:0]  issued_q;
  logic              error_q;

  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic              rdy_found;
  logic [IDX_W-1:0]  rdy_idx;
  logic [AGE_W-1:0]  rdy_age;
  logic              accept;
  logic              retire;
  logic [TAG_W-1:0]  qj_d, qk_d;
  logic [DATA_W-1:0] vj_d, vk_d;
  logic [DATA_W-1:0] alu_res;

  function automatic logic [TAG_W-1:0] idx_tag(input logic [IDX_W-1:0] idx);
    return TAG_W'(RS_BASE) + TAG_W'(idx);
  endfunction

  // Lowest-index free station
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Oldest ready station, from registered state only
  always_comb begin
    rdy_found = 1'b0;
    rdy_idx   = '0;
    rdy_age   = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      if (busy_q[i] && qj_q[i] == '0 && qk_q[i] == '0 &&
          (!rdy_found || age_q[i] > rdy_age)) begin
        rdy_found = 1'b1;
        rdy_idx   = IDX_W'(i);
        rdy_age   = age_q[i];
      end
    end
  end

  // Operand capture at issue, including same-cycle CDB bypass
  always_comb begin
    qj_d = '0;
    vj_d = A;
    qk_d = '0;
    vk_d = B;
    if (A_invalid) begin
      if (cdb_valid && cdb_tag == A[TAG_W-1:0]) begin
        vj_d = cdb_data;
      end else begin
        qj_d = A[TAG_W-1:0];
        vj_d = '0;
      end
    end
    if (B_invalid) begin
      if (cdb_valid && cdb_tag == B[TAG_W-1:0]) begin
        vk_d = cdb_data;
      end else begin
        qk_d = B[TAG_W-1:0];
        vk_d = '0;
      end
    end
  end

  // ALU datapath on the station currently in execution
  always_comb begin
    case (op_q[exec_idx_q])
      3'b000:  alu_res = vj_q[exec_idx_q] + vk_q[exec_idx_q];
      3'b001:  alu_res = vj_q[exec_idx_q] - vk_q[exec_idx_q];
      3'b100:  alu_res = vj_q[exec_idx_q] | vk_q[exec_idx_q];
      3'b101:  alu_res = vj_q[exec_idx_q] & vk_q[exec_idx_q];
      3'b110:  alu_res = ~vj_q[exec_idx_q];
      3'b111:  alu_res = vj_q[exec_idx_q] ^ vk_q[exec_idx_q];
      default: alu_res = '0;
    endcase
  end

  assign accept = issue & free_found;
  assign retire = (state_q == ALU_WAIT) & cdb_grant;

  // Station update: issue, snoop, retire and relative age tracking.
  // Age counts live stations issued after this one, so it stays below NUM_RS
  // and the ordering survives any number of issues.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_RS; i++) begin
        busy_q[i] <= 1'b0;
        op_q[i]   <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_RS; i++) begin
        if (busy_q[i]) begin
          if (cdb_valid && qj_q[i] != '0 && qj_q[i] == cdb_tag) begin
            qj_q[i] <= '0;
            vj_q[i] <= cdb_data;
          end
          if (cdb_valid && qk_q[i] != '0 && qk_q[i] == cdb_tag) begin
            qk_q[i] <= '0;
            vk_q[i] <= cdb_data;
          end
          if (retire && exec_idx_q == IDX_W'(i)) begin
            busy_q[i] <= 1'b0;
          end
          age_q[i] <= age_q[i] + AGE_W'(accept)
                    - AGE_W'(retire && (age_q[i] > age_q[exec_idx_q]));
        end else if (accept && free_idx == IDX_W'(i)) begin
          busy_q[i] <= 1'b1;
          op_q[i]   <= opcode;
          qj_q[i]   <= qj_d;
          vj_q[i]   <= vj_d;
          qk_q[i]   <= qk_d;
          vk_q[i]   <= vk_d;
          age_q[i]  <= '0;
        end
      end
    end
  end

  // Issue handshake pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      issued_q <= '0;
      error_q  <= 1'b0;
    end else begin
      issued_q <= accept ? idx_tag(free_idx) : '0;
      error_q  <= issue & ~free_found;
    end
  end

  // ALU FSM: dispatch, count down latency, hold result until granted
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ALU_IDLE;
      exec_idx_q <= '0;
      cnt_q      <= '0;
      cdb_rts_q  <= 1'b0;
      out_tag_q  <= '0;
      out_data_q <= '0;
      rs_exec_q  <= '0;
    end else begin
      case (state_q)
        ALU_IDLE: begin
          if (rdy_found) begin
            state_q    <= ALU_EXEC;
            exec_idx_q <= rdy_idx;
            cnt_q      <= CNT_W'(LATENCY - 1);
            rs_exec_q  <= idx_tag(rdy_idx);
          end
        end
        ALU_EXEC: begin
          if (cnt_q == '0) begin
            state_q    <= ALU_WAIT;
            cdb_rts_q  <= 1'b1;
            out_tag_q  <= rs_exec_q;
            out_data_q <= alu_res;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ALU_WAIT: begin
          if (cdb_grant) begin
            state_q    <= ALU_IDLE;
            cdb_rts_q  <= 1'b0;
            out_tag_q  <= '0;
            out_data_q <= '0;
            rs_exec_q  <= '0;
          end
        end
        default: state_q <= ALU_IDLE;
      endcase
    end
  end

  assign cdb_rts       = cdb_rts_q;
  assign cdb_out_valid = cdb_rts_q & cdb_grant;
  assign cdb_out_tag   = out_tag_q;
  assign cdb_out_data  = out_data_q;
  assign available     = free_found;
  assign rs_available  = free_found ? idx_tag(free_idx) : '0;
  assign issued        = issued_q;
  assign rs_executing  = rs_exec_q;
  assign error         = error_q;

endmodule

// File: tb/tb_adder_rs_array.sv
// Testbench for adder_rs_array: operation table, directed corner sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_adder_rs_array;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 6;
  localparam int NUM_RS  = 4;
  localparam int RS_BASE = 1;
  localparam int LATENCY = 2;

  logic              clock = 1'b0;
  logic              reset, issue, A_invalid, B_invalid, cdb_valid, cdb_grant;
  logic [2:0]        opcode;
  logic [DATA_W-1:0] A, B, cdb_data;
  logic [TAG_W-1:0]  cdb_tag;
  logic              cdb_rts, cdb_out_valid, available, error;
  logic [TAG_W-1:0]  cdb_out_tag, rs_available, issued, rs_executing;
  logic [DATA_W-1:0] cdb_out_data;

  always #5 clock = ~clock;

  adder_rs_array #(
    .DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_RS(NUM_RS), .RS_BASE(RS_BASE), .LATENCY(LATENCY)
  ) dut (
    .clock(clock), .reset(reset), .issue(issue), .opcode(opcode), .A(A), .B(B),
    .A_invalid(A_invalid), .B_invalid(B_invalid), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_grant(cdb_grant),
    .cdb_rts(cdb_rts), .cdb_out_valid(cdb_out_valid), .cdb_out_tag(cdb_out_tag),
    .cdb_out_data(cdb_out_data), .available(available), .rs_available(rs_available),
    .issued(issued), .rs_executing(rs_executing), .error(error)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  bit                m_busy [NUM_RS];
  logic [2:0]        m_op   [NUM_RS];
  logic [TAG_W-1:0]  m_qj   [NUM_RS];
  logic [TAG_W-1:0]  m_qk   [NUM_RS];
  logic [DATA_W-1:0] m_vj   [NUM_RS];
  logic [DATA_W-1:0] m_vk   [NUM_RS];
  longint            m_stamp[NUM_RS];
  longint            m_next_stamp = 0;
  longint            m_edge = 0;
  longint            m_done = 0;
  bit                m_alu = 0, m_rts = 0, m_err = 0;
  int                m_idx = 0;
  logic [DATA_W-1:0] m_res = '0;
  logic [TAG_W-1:0]  m_issued = '0;

  function automatic logic [DATA_W-1:0] alu(input logic [2:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b100:  return a | b;
      3'b101:  return a & b;
      3'b110:  return ~a;
      3'b111:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  task automatic model_step();
    int  free_i = -1;
    int  cand = -1;
    bit  fire;
    m_edge++;
    for (int i = 0; i < NUM_RS; i++)
      if (!m_busy[i] && free_i < 0) free_i = i;
    if (!m_alu)
      for (int i = 0; i < NUM_RS; i++)
        if (m_busy[i] && m_qj[i] == '0 && m_qk[i] == '0 && (cand < 0 || m_stamp[i] < m_stamp[cand]))
          cand = i;
    fire = m_rts && cdb_grant;
    if (reset) begin
      for (int i = 0; i < NUM_RS; i++) m_busy[i] = 0;
      m_alu = 0; m_rts = 0; m_err = 0; m_issued = '0;
      return;
    end
    if (cdb_valid)
      for (int i = 0; i < NUM_RS; i++)
        if (m_busy[i]) begin
          if (m_qj[i] != '0 && m_qj[i] == cdb_tag) begin m_qj[i] = '0; m_vj[i] = cdb_data; end
          if (m_qk[i] != '0 && m_qk[i] == cdb_tag) begin m_qk[i] = '0; m_vk[i] = cdb_data; end
        end
    m_issued = '0;
    m_err = 0;
    if (issue) begin
      if (free_i < 0) m_err = 1;
      else begin
        m_busy[free_i] = 1;
        m_op[free_i] = opcode;
        m_stamp[free_i] = m_next_stamp++;
        if (A_invalid && !(cdb_valid && cdb_tag == A[TAG_W-1:0])) begin
          m_qj[free_i] = A[TAG_W-1:0]; m_vj[free_i] = '0;
        end else begin
          m_qj[free_i] = '0; m_vj[free_i] = A_invalid ? cdb_data : A;
        end
        if (B_invalid && !(cdb_valid && cdb_tag == B[TAG_W-1:0])) begin
          m_qk[free_i] = B[TAG_W-1:0]; m_vk[free_i] = '0;
        end else begin
          m_qk[free_i] = '0; m_vk[free_i] = B_invalid ? cdb_data : B;
        end
        m_issued = TAG_W'(RS_BASE + free_i);
      end
    end
    if (fire) begin
      m_busy[m_idx] = 0; m_rts = 0; m_alu = 0;
    end else if (m_alu && !m_rts && m_edge == m_done) begin
      m_rts = 1;
      m_res = alu(m_op[m_idx], m_vj[m_idx], m_vk[m_idx]);
    end else if (!m_alu && cand >= 0) begin
      m_alu = 1; m_idx = cand; m_done = m_edge + LATENCY;
    end
  endtask

  task automatic check_outputs(input string ctx);
    int free_i = -1;
    for (int i = 0; i < NUM_RS; i++)
      if (!m_busy[i] && free_i < 0) free_i = i;
    chk({ctx, "/cdb_rts"}, 64'(cdb_rts), 64'(m_rts));
    chk({ctx, "/cdb_out_valid"}, 64'(cdb_out_valid), 64'(m_rts & cdb_grant));
    chk({ctx, "/cdb_out_tag"}, 64'(cdb_out_tag), m_rts ? 64'(RS_BASE + m_idx) : 64'd0);
    chk({ctx, "/cdb_out_data"}, 64'(cdb_out_data), m_rts ? 64'(m_res) : 64'd0);
    chk({ctx, "/available"}, 64'(available), 64'(free_i >= 0));
    chk({ctx, "/rs_available"}, 64'(rs_available), free_i >= 0 ? 64'(RS_BASE + free_i) : 64'd0);
    chk({ctx, "/issued"}, 64'(issued), 64'(m_issued));
    chk({ctx, "/error"}, 64'(error), 64'(m_err));
    chk({ctx, "/rs_executing"}, 64'(rs_executing), m_alu ? 64'(RS_BASE + m_idx) : 64'd0);
  endtask

  task automatic cycle(input string ctx);
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_outputs(ctx);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_idle();
    issue = 0; A_invalid = 0; B_invalid = 0; cdb_valid = 0; cdb_tag = '0; cdb_data = '0; reset = 0;
  endtask

  task automatic do_reset(input string ctx);
    reset = 1; cycle(ctx); reset = 0;
  endtask

  task automatic do_issue(input string ctx, input logic [2:0] op, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b, input logic ainv, input logic binv);
    issue = 1; opcode = op; A = a; B = b; A_invalid = ainv; B_invalid = binv;
    cycle(ctx);
    issue = 0; A_invalid = 0; B_invalid = 0;
  endtask

  task automatic wait_valid(input string ctx, output int n);
    n = 0;
    while (cdb_out_valid !== 1'b1 && n < 40) begin cycle(ctx); n++; end
    if (cdb_out_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s timeout waiting for cdb_out_valid", ctx);
    end
  endtask

  task automatic wait_rts(input string ctx);
    int n = 0;
    while (cdb_rts !== 1'b1 && n < 40) begin cycle(ctx); n++; end
    if (cdb_rts !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s timeout waiting for cdb_rts", ctx);
    end
  endtask

  task automatic chk_reset_state(input string ctx);
    chk({ctx, "/rst_rts"}, 64'(cdb_rts), 64'd0);
    chk({ctx, "/rst_valid"}, 64'(cdb_out_valid), 64'd0);
    chk({ctx, "/rst_tag"}, 64'(cdb_out_tag), 64'd0);
    chk({ctx, "/rst_data"}, 64'(cdb_out_data), 64'd0);
    chk({ctx, "/rst_issued"}, 64'(issued), 64'd0);
    chk({ctx, "/rst_exec"}, 64'(rs_executing), 64'd0);
    chk({ctx, "/rst_error"}, 64'(error), 64'd0);
    chk({ctx, "/rst_avail"}, 64'(available), 64'd1);
    chk({ctx, "/rst_rs_avail"}, 64'(rs_available), 64'(RS_BASE));
  endtask

  function automatic logic [TAG_W-1:0] pick_tag();
    int unsigned x = $urandom_range(0, 7);
    return (x < 4) ? TAG_W'(1 + x) : TAG_W'(16 + x);
  endfunction

  typedef struct {
    logic [2:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] res;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int n;
    int pulses;
    int order[$];
    logic [TAG_W-1:0] prev_exec;

    tbl[0] = '{3'b000, 32'd5,          32'd7,          32'd12};
    tbl[1] = '{3'b001, 32'd100,        32'd1,          32'd99};
    tbl[2] = '{3'b001, 32'd0,          32'd1,          32'hFFFF_FFFF};
    tbl[3] = '{3'b000, 32'hFFFF_FFFF,  32'd2,          32'd1};
    tbl[4] = '{3'b100, 32'hF0F0_0000,  32'h0000_0F0F,  32'hF0F0_0F0F};
    tbl[5] = '{3'b101, 32'hFF00_FF00,  32'h0F0F_0F0F,  32'h0F00_0F00};
    tbl[6] = '{3'b110, 32'h1234_5678,  32'h0000_FFFF,  32'hEDCB_A987};
    tbl[7] = '{3'b111, 32'hAAAA_AAAA,  32'hFFFF_0000,  32'h5555_AAAA};
    tbl[8] = '{3'b010, 32'd3,          32'd4,          32'd0};
    tbl[9] = '{3'b011, 32'd3,          32'd4,          32'd0};

    opcode = '0; A = '0; B = '0; cdb_grant = 0;
    drive_idle();
    @(negedge clock);
    do_reset("reset");
    chk_reset_state("reset");

    // Test 1: single add, grant tied high, latency from the issue edge
    cdb_grant = 1;
    do_issue("t1", 3'b000, 32'd5, 32'd7, 0, 0);
    chk("t1/issued", 64'(issued), 64'd1);
    wait_valid("t1", n);
    chk("t1/latency", 64'(n), 64'(1 + LATENCY));
    chk("t1/tag", 64'(cdb_out_tag), 64'd1);
    chk("t1/data", 64'(cdb_out_data), 64'd12);
    cycle("t1");

    // Operation table
    for (int i = 0; i < 10; i++) begin
      do_issue("tbl", tbl[i].op, tbl[i].a, tbl[i].b, 0, 0);
      wait_valid("tbl", n);
      chk($sformatf("tbl%0d/data", i), 64'(cdb_out_data), 64'(tbl[i].res));
      chk($sformatf("tbl%0d/tag", i), 64'(cdb_out_tag), 64'd1);
      cycle("tbl");
    end

    // Test 2: fill all stations, overflow, then free one
    do_reset("t2");
    cdb_grant = 0;
    for (int i = 0; i < NUM_RS; i++) begin
      do_issue("t2", 3'b000, 32'(i), 32'd1, 0, 0);
      chk($sformatf("t2/issued%0d", i), 64'(issued), 64'(RS_BASE + i));
    end
    do_issue("t2ovf", 3'b000, 32'd9, 32'd9, 0, 0);
    chk("t2/error", 64'(error), 64'd1);
    chk("t2/issued_ovf", 64'(issued), 64'd0);
    chk("t2/avail_full", 64'(available), 64'd0);
    chk("t2/rs_avail_full", 64'(rs_available), 64'd0);
    cycle("t2");
    chk("t2/error_pulse", 64'(error), 64'd0);
    cdb_grant = 1;
    cycle("t2");
    cdb_grant = 0;
    chk("t2/avail_freed", 64'(available), 64'd1);
    chk("t2/rs_avail_freed", 64'(rs_available), 64'd1);

    // Test 3: tagged operand via snoop, then via issue-cycle bypass
    do_reset("t3");
    cdb_grant = 1;
    do_issue("t3", 3'b001, 32'd9, 32'd1, 1, 0);
    cdb_valid = 1; cdb_tag = 6'd9; cdb_data = 32'd100;
    cycle("t3");
    drive_idle();
    wait_valid("t3", n);
    chk("t3/snoop_data", 64'(cdb_out_data), 64'd99);
    cycle("t3");
    cdb_valid = 1; cdb_tag = 6'd9; cdb_data = 32'd100;
    do_issue("t3b", 3'b001, 32'd9, 32'd1, 1, 0);
    drive_idle();
    wait_valid("t3b", n);
    chk("t3/bypass_data", 64'(cdb_out_data), 64'd99);
    cycle("t3b");

    // Test 4: dispatch order 2, then 1 (older), then 3
    do_reset("t4");
    cdb_grant = 1;
    do_issue("t4", 3'b000, 32'd20, 32'd1, 1, 0);
    do_issue("t4", 3'b000, 32'd21, 32'd2, 1, 0);
    do_issue("t4", 3'b000, 32'd20, 32'd3, 1, 0);
    prev_exec = rs_executing;
    cdb_valid = 1; cdb_tag = 6'd21; cdb_data = 32'd10;
    cycle("t4");
    cdb_tag = 6'd20; cdb_data = 32'd30;
    cycle("t4");
    drive_idle();
    for (int c = 0; c < 30; c++) begin
      if (rs_executing != '0 && rs_executing != prev_exec) order.push_back(int'(rs_executing));
      prev_exec = rs_executing;
      cycle("t4");
    end
    chk("t4/count", 64'(order.size()), 64'd3);
    while (order.size() < 3) order.push_back(0);
    chk("t4/first", 64'(order[0]), 64'd2);
    chk("t4/second", 64'(order[1]), 64'd1);
    chk("t4/third", 64'(order[2]), 64'd3);

    // Test 5: result held with grant low, one-cycle grant gives one pulse
    do_reset("t5");
    cdb_grant = 0;
    do_issue("t5", 3'b000, 32'd1, 32'd2, 0, 0);
    wait_rts("t5");
    for (int c = 0; c < 10; c++) begin
      cycle("t5hold");
      chk("t5/rts_held", 64'(cdb_rts), 64'd1);
      chk("t5/tag_held", 64'(cdb_out_tag), 64'd1);
      chk("t5/data_held", 64'(cdb_out_data), 64'd3);
    end
    pulses = 0;
    cdb_grant = 1;
    #1 pulses += int'(cdb_out_valid);
    cycle("t5");
    cdb_grant = 0;
    for (int c = 0; c < 5; c++) begin
      #1 pulses += int'(cdb_out_valid);
      cycle("t5");
    end
    chk("t5/pulses", 64'(pulses), 64'd1);

    // Test 6: reset during EXEC and during WAIT drops the result
    do_reset("t6");
    cdb_grant = 0;
    do_issue("t6", 3'b000, 32'd4, 32'd4, 0, 0);
    cycle("t6");
    chk("t6/in_exec", 64'(rs_executing), 64'd1);
    do_reset("t6exec");
    chk_reset_state("t6exec");
    cdb_grant = 1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin cycle("t6"); pulses += int'(cdb_out_valid); end
    chk("t6/no_bcast_exec", 64'(pulses), 64'd0);
    cdb_grant = 0;
    do_issue("t6", 3'b000, 32'd4, 32'd4, 0, 0);
    wait_rts("t6");
    do_reset("t6wait");
    chk_reset_state("t6wait");
    cdb_grant = 1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin cycle("t6"); pulses += int'(cdb_out_valid); end
    chk("t6/no_bcast_wait", 64'(pulses), 64'd0);

    // Randomized traffic against the model
    do_reset("rand");
    for (int c = 0; c < 3000; c++) begin
      issue     = ($urandom_range(0, 1) == 1);
      opcode    = 3'($urandom_range(0, 7));
      A         = $urandom;
      B         = $urandom;
      A_invalid = ($urandom_range(0, 3) == 0);
      B_invalid = ($urandom_range(0, 3) == 0);
      if (A_invalid) A[TAG_W-1:0] = pick_tag();
      if (B_invalid) B[TAG_W-1:0] = pick_tag();
      cdb_valid = ($urandom_range(0, 9) < 4);
      cdb_tag   = pick_tag();
      cdb_data  = $urandom;
      cdb_grant = ($urandom_range(0, 9) < 6);
      reset     = ($urandom_range(0, 99) == 0);
      cycle("rand");
    end
    drive_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
